// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_sequencer_pkg                                             |
// | Purpose  : Shared fetch-stage definitions: sequencer FSM state encoding,   |
// |            the canonical NOP word and the default reset vector.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] c_NOP       = 32'h0000_0013;
  localparam logic [31:0] c_RESET_VEC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_redirect_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_redirect_mux                                                 |
// | Purpose  : Fixed-priority selection of the PC redirect source.             |
// |            Priority: trap > EX branch > ID jump.                           |
// | Ports    : trap_req/trap_pc, br_taken/br_target, jmp_req/jmp_target in;   |
// |            redirect_valid, redirect_target out (combinational).            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pc_redirect_mux
  import fetch_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_req,
  input  logic [XLEN-1:0] jmp_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_target
);

  always_comb begin
    redirect_valid = trap_req | br_taken | jmp_req;
    if (trap_req) begin
      redirect_target = trap_pc;
    end else if (br_taken) begin
      redirect_target = br_target;
    end else begin
      redirect_target = jmp_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_sequencer                                                 |
// | Purpose  : Fetch-stage PC sequencer with a single-outstanding instruction  |
// |            memory handshake, redirect arbitration, stale-response drop    |
// |            and an IF/ID holding slot for hazard stalls.                    |
// | Ports    : clk, reset (async, active-high)                                 |
// |            stall                          - IF/ID cannot accept           |
// |            trap_*/br_*/jmp_*              - redirect sources              |
// |            imem_req/addr/gnt/rvalid/rdata - instruction memory port       |
// |            if_valid/if_pc/if_instr        - to IF/ID register             |
// |            pc_next                        - next fetch PC (trace)         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(c_RESET_VEC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_req,
  input  logic [XLEN-1:0] jmp_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] pc_next
);

  fetch_state_t    r_state, w_state_next;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic [XLEN-1:0] r_req_pc, w_req_pc_next;
  logic            r_drop, w_drop_next;
  logic            r_if_valid, w_if_valid_next;
  logic [XLEN-1:0] r_if_pc, w_if_pc_next;
  logic [XLEN-1:0] r_if_instr, w_if_instr_next;

  logic            w_rd_valid;
  logic [XLEN-1:0] w_rd_target;
  logic            w_accept;

  pc_redirect_mux #(.XLEN(XLEN)) u_redirect_mux (
    .trap_req        (trap_req),
    .trap_pc         (trap_pc),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .jmp_req         (jmp_req),
    .jmp_target      (jmp_target),
    .redirect_valid  (w_rd_valid),
    .redirect_target (w_rd_target)
  );

  // A response is only kept if it belongs to a live fetch and no redirect
  // lands in the same cycle; rvalid outside WAIT is ignored entirely.
  assign w_accept = (r_state == ST_WAIT) && imem_rvalid && !r_drop && !w_rd_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_VEC;
      r_req_pc   <= RESET_VEC;
      r_drop     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= XLEN'(c_NOP);
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_req_pc   <= w_req_pc_next;
      r_drop     <= w_drop_next;
      r_if_valid <= w_if_valid_next;
      r_if_pc    <= w_if_pc_next;
      r_if_instr <= w_if_instr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_req_pc_next   = r_req_pc;
    w_drop_next     = r_drop;
    // if_valid is a one-cycle presentation unless HOLD keeps it alive.
    w_if_valid_next = 1'b0;
    w_if_pc_next    = r_if_pc;
    w_if_instr_next = r_if_instr;

    // PC is loaded every edge; wraps modulo 2^XLEN naturally.
    if (w_rd_valid) begin
      w_pc_next = w_rd_target;
    end else if (w_accept) begin
      w_pc_next = r_req_pc + XLEN'(4);
    end else begin
      w_pc_next = r_pc;
    end

    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_REQ;
      end

      ST_REQ: begin
        if (imem_gnt) begin
          w_state_next  = ST_WAIT;
          w_req_pc_next = r_pc;
          // Granted address is already stale if a redirect hits this cycle.
          w_drop_next   = w_rd_valid;
        end
      end

      ST_WAIT: begin
        if (imem_rvalid) begin
          w_drop_next = 1'b0;
          if (w_accept) begin
            w_if_valid_next = 1'b1;
            w_if_pc_next    = r_req_pc;
            w_if_instr_next = imem_rdata;
            w_state_next    = stall ? ST_HOLD : ST_REQ;
          end else begin
            w_state_next = ST_REQ;
          end
        end else if (w_rd_valid) begin
          w_drop_next = 1'b1;
        end
      end

      ST_HOLD: begin
        if (w_rd_valid || !stall) begin
          w_state_next = ST_REQ;
        end else begin
          w_if_valid_next = 1'b1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign imem_req  = (r_state == ST_REQ);
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;
  assign pc_next   = w_pc_next;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_sequencer                                              |
// | Purpose  : Self-checking bench for fetch_sequencer. A memory agent answers |
// |            requests with configurable/random grant delay and latency; a   |
// |            transaction-level model predicts PC flow and deliveries.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

  localparam logic [31:0] c_RST_VEC = 32'h0000_0000;
  localparam logic [31:0] c_NOP_W   = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        trap_req, br_taken, jmp_req;
  logic [31:0] trap_pc, br_target, jmp_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_instr, pc_next;

  fetch_sequencer #(.XLEN(32), .RESET_VEC(c_RST_VEC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .trap_req    (trap_req),
    .trap_pc     (trap_pc),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_req     (jmp_req),
    .jmp_target  (jmp_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .pc_next     (pc_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // memory agent state
  bit          mem_out;
  logic [31:0] mem_addr;
  int          mem_lat, mem_wait;
  int          gnt_delay, rlat;
  bit          rand_mode;

  // reference model state
  logic [31:0] m_pc, m_faddr, m_show_pc;
  bit          m_live, m_show, m_hold;

  // observation logs
  logic [31:0] gnt_log[$];
  logic [31:0] dlv_log[$];
  bit          prev_if_valid, last_gnt;
  int          req10_cnt;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0055_AA13 ^ {a[31:16], 16'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_pc = c_RST_VEC; m_faddr = '0; m_show_pc = '0;
    m_live = 0; m_show = 0; m_hold = 0;
    mem_out = 0; mem_addr = '0; mem_lat = 0; mem_wait = 0;
    prev_if_valid = 0; last_gnt = 0;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic tick();
    logic        rd, deliver;
    logic [31:0] tgt, exp_next, dpc;
    imem_rvalid = mem_out && (mem_lat == 0);
    imem_rdata  = imem_rvalid ? memfn(mem_addr) : 32'h0;
    imem_gnt    = imem_req && (mem_wait >= gnt_delay);
    #1;
    rd  = trap_req | br_taken | jmp_req;
    tgt = trap_req ? trap_pc : (br_taken ? br_target : jmp_target);

    chk("if_valid", if_valid, m_show);
    if (m_show) begin
      chk("if_pc", if_pc, m_show_pc);
      chk("if_instr", if_instr, memfn(m_show_pc));
    end
    if (imem_req) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("single_outstanding", mem_out, 1'b0);
    end
    exp_next = rd ? tgt : ((imem_rvalid && m_live) ? m_faddr + 32'd4 : m_pc);
    chk("pc_next", pc_next, exp_next);

    if (imem_gnt) gnt_log.push_back(imem_addr);
    if (if_valid && !prev_if_valid) dlv_log.push_back(if_pc);
    if (imem_req && imem_addr == 32'h10) req10_cnt++;
    prev_if_valid = if_valid;
    last_gnt      = imem_gnt;

    // model: architectural PC and the single live fetch
    deliver = imem_rvalid && m_live && !rd;
    dpc     = m_faddr;
    if (imem_rvalid) m_live = 0;
    if (deliver) m_pc = dpc + 32'd4;
    if (imem_gnt) begin m_faddr = imem_addr; m_live = !rd; end
    if (rd) begin m_pc = tgt; m_live = 0; end
    if (rd) begin
      m_show = 0; m_hold = 0;
    end else if (deliver) begin
      m_show = 1; m_hold = stall; m_show_pc = dpc;
    end else if (!(m_show && m_hold && stall)) begin
      m_show = 0; m_hold = 0;
    end

    // memory agent
    if (imem_rvalid) mem_out = 0;
    else if (mem_out) mem_lat--;
    if (imem_gnt) begin
      mem_out  = 1;
      mem_addr = imem_addr;
      mem_lat  = rand_mode ? int'($urandom_range(0, 3)) : rlat;
      mem_wait = 0;
      if (rand_mode) gnt_delay = int'($urandom_range(0, 3));
    end else if (imem_req) mem_wait++;
    else mem_wait = 0;

    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; stall = 0;
    trap_req = 0; br_taken = 0; jmp_req = 0;
    trap_pc = '0; br_target = '0; jmp_target = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    gnt_delay = 0; rlat = 0; rand_mode = 0; req10_cnt = 0;
    reset_model();
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, c_NOP_W);
    chk("rst_imem_addr", imem_addr, c_RST_VEC);
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    #1;
    chk("idle_no_req", imem_req, 1'b0);

    // A: zero-wait sequential fetch
    for (int n = 0; n < 40 && dlv_log.size() < 3; n++) tick();
    chk("A_dlv_cnt", (dlv_log.size() >= 3), 1'b1);
    if (dlv_log.size() >= 3 && gnt_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("A_gnt_addr", gnt_log[i], 32'(4 * i));
        chk("A_dlv_pc", dlv_log[i], 32'(4 * i));
      end
    end

    // B: grant delayed by 3 cycles
    gnt_delay = 3; req10_cnt = 0;
    for (int n = 0; n < 80 && !(dlv_log.size() > 0 && dlv_log[$] == 32'h10); n++) tick();
    chk("B_dlv_0x10", dlv_log[$], 32'h10);
    chk("B_req_cycles", req10_cnt, 4);

    // C: branch while waiting on 0x20
    gnt_delay = 0; rlat = 2;
    for (int n = 0; n < 40 && !(gnt_log[$] == 32'h20 && mem_out); n++) tick();
    chk("C_wait_0x20", gnt_log[$], 32'h20);
    br_taken = 1; br_target = 32'h100;
    tick();
    br_taken = 0;
    gnt_log.delete(); dlv_log.delete();
    for (int n = 0; n < 40 && dlv_log.size() == 0; n++) tick();
    chk("C_dlv_pc", dlv_log.size() > 0 ? dlv_log[0] : 32'hFFFF_FFFF, 32'h100);
    chk("C_next_gnt", gnt_log.size() > 0 ? gnt_log[0] : 32'hFFFF_FFFF, 32'h100);

    // D: simultaneous redirects
    rlat = 0;
    trap_req = 1; trap_pc = 32'h80;
    br_taken = 1; br_target = 32'h200;
    jmp_req = 1; jmp_target = 32'h300;
    tick();
    trap_req = 0; br_taken = 0; jmp_req = 0;
    gnt_log.delete();
    for (int n = 0; n < 20 && gnt_log.size() == 0; n++) tick();
    chk("D_prio_gnt", gnt_log.size() > 0 ? gnt_log[0] : 32'hFFFF_FFFF, 32'h80);

    // E: stall after response for 0x40
    jmp_req = 1; jmp_target = 32'h40;
    tick();
    jmp_req = 0; stall = 1;
    for (int n = 0; n < 30 && !(if_valid && if_pc == 32'h40); n++) tick();
    for (int i = 0; i < 4; i++) begin
      chk("E_hold_valid", if_valid, 1'b1);
      chk("E_hold_pc", if_pc, 32'h40);
      chk("E_hold_instr", if_instr, memfn(32'h40));
      chk("E_hold_noreq", imem_req, 1'b0);
      tick();
    end
    stall = 0;
    gnt_log.delete();
    for (int n = 0; n < 20 && gnt_log.size() == 0; n++) tick();
    chk("E_next_gnt", gnt_log.size() > 0 ? gnt_log[0] : 32'hFFFF_FFFF, 32'h44);

    // H: PC wrap at the top of the address space
    jmp_req = 1; jmp_target = 32'hFFFF_FFFC;
    tick();
    jmp_req = 0;
    gnt_log.delete();
    for (int n = 0; n < 20 && gnt_log.size() < 2; n++) tick();
    chk("H_gnt_top", gnt_log.size() > 1 ? gnt_log[0] : 32'h1, 32'hFFFF_FFFC);
    chk("H_gnt_wrap", gnt_log.size() > 1 ? gnt_log[1] : 32'h1, 32'h0);

    // F: random traffic against the model
    rand_mode = 1;
    for (int n = 0; n < 400; n++) begin
      stall      = ($urandom_range(0, 3) == 0);
      trap_req   = ($urandom_range(0, 49) == 0);
      trap_pc    = $urandom;
      br_taken   = ($urandom_range(0, 24) == 0);
      br_target  = $urandom;
      jmp_req    = ($urandom_range(0, 24) == 0);
      jmp_target = $urandom;
      tick();
    end
    rand_mode = 0; stall = 0;
    trap_req = 0; br_taken = 0; jmp_req = 0;
    gnt_delay = 0; rlat = 3;

    // G: reset while waiting, then a late response
    for (int n = 0; n < 30 && !last_gnt; n++) tick();
    chk("G_in_wait", last_gnt, 1'b1);
    #1 reset = 1;
    #1;
    chk("G_rst_req", imem_req, 1'b0);
    chk("G_rst_valid", if_valid, 1'b0);
    chk("G_rst_pc", if_pc, 32'h0);
    chk("G_rst_instr", if_instr, c_NOP_W);
    chk("G_rst_addr", imem_addr, c_RST_VEC);
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("G_late_valid", if_valid, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("G_idle_req", imem_req, 1'b0);
    chk("G_idle_pcnext", pc_next, c_RST_VEC);
    @(posedge clk); #1;
    imem_rvalid = 0;
    chk("G_after_late", if_valid, 1'b0);
    reset_model();
    gnt_log.delete(); dlv_log.delete();
    rlat = 0;
    for (int n = 0; n < 20 && dlv_log.size() == 0; n++) tick();
    chk("G_first_gnt", gnt_log.size() > 0 ? gnt_log[0] : 32'hFFFF_FFFF, c_RST_VEC);
    chk("G_first_dlv", dlv_log.size() > 0 ? dlv_log[0] : 32'hFFFF_FFFF, c_RST_VEC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
